fan_ctrl_sequencer: RTL and testbench
=====================================

Name: fan_ctrl_sequencer

Overview:
Sequences one control step of the fan datapath once per sample period. Each step runs three phases in order: request an ADC conversion, launch one PID iteration with the sampled temperature and setpoint, then latch the post-processed controller output as the PWM duty command. It sits between the ADC front-end and the PI/PID + PWM datapath, and replaces the free-running clk_en tie-off with an explicit start/done handshake per phase.

Parameters:
ADC_BITWIDTH, 4, width of ADC sample, setpoint and duty command
TICK_PERIOD, 200000, clk_i cycles per control step (200 ms at 1 MHz); legal range is 16 or greater
ADC_TIMEOUT, 255, maximum cycles to wait for adc_done_i before aborting the step
PWM_MIN_DUTY, 3, minimum non-zero duty command

Ports:
clk_i  in  1  system clock, 1 MHz
rst_i  in  1  synchronous reset, active high
enable_i  in  1  run enable; when low, no new step starts
set_i  in  ADC_BITWIDTH  setpoint, sampled at step start
adc_start_o  out  1  single-cycle conversion request
adc_done_i  in  1  single-cycle conversion complete; adc_data_i is valid in the same cycle
adc_data_i  in  ADC_BITWIDTH  conversion result
pid_start_o  out  1  single-cycle PID iteration request
pid_busy_i  in  1  PID iteration in progress
pid_result_i  in  ADC_BITWIDTH+1  signed PID output
adc_sample_o  out  ADC_BITWIDTH  latched ADC value fed to the PID
set_sample_o  out  ADC_BITWIDTH  latched setpoint fed to the PID
duty_o  out  ADC_BITWIDTH  PWM duty command
duty_valid_o  out  1  single-cycle pulse when duty_o updates
timeout_o  out  1  sticky ADC-timeout flag

Behaviour:
- Reset: synchronous and active high. The clock is clk_i and the reset is rst_i. On reset the state machine enters IDLE, the tick counter is cleared, and every output is 0, including timeout_o. Reset asserted in any state aborts the step in progress immediately; no partial update of duty_o occurs.
- Tick counter: free-runs from 0 to TICK_PERIOD-1 and then wraps. It produces a one-cycle tick when count equals TICK_PERIOD-1. It keeps counting while a step is in progress and while enable_i is low.
- State transitions:
  - IDLE: on a tick with enable_i=1, latch set_i into set_sample_o and go to ADC_REQ. A tick with enable_i=0 is ignored.
  - ADC_REQ: assert adc_start_o for exactly 1 cycle, clear the wait counter, go to ADC_WAIT.
  - ADC_WAIT: on adc_done_i, latch adc_data_i into adc_sample_o and go to PID_REQ. If the wait counter reaches ADC_TIMEOUT first, set timeout_o and return to IDLE. In the timeout case duty_o is unchanged and no pid_start_o is issued.
  - PID_REQ: assert pid_start_o for 1 cycle, go to PID_WAIT.
  - PID_WAIT: ignore the first cycle, because busy may lag start by 1 cycle. After that, when pid_busy_i=0, go to UPDATE.
  - UPDATE: register the mapped duty, pulse duty_valid_o for 1 cycle, return to IDLE.
- Duty mapping of signed r = pid_result_i:
  - r ≤ 0 gives duty 0.
  - 0 < r < PWM_MIN_DUTY gives PWM_MIN_DUTY.
  - Otherwise duty = r[ADC_BITWIDTH-1:0]. With the default widths r is at most 15, so this is never truncated.
- Overrun: a tick that arrives while not in IDLE is dropped. The step in progress completes normally, and the next step starts on the following tick.
- adc_done_i arriving outside ADC_WAIT is ignored.
- timeout_o clears only on reset.
- Latency, from tick to duty_valid_o:
  - 1 cycle for IDLE to ADC_REQ
  - 1 cycle for ADC_REQ
  - ADC wait time
  - 1 cycle for PID_REQ
  - at least 2 cycles for PID_WAIT
  - 1 cycle for UPDATE

Optional Feature:
FAN_SEQ_OVERSAMPLE_EN:
- Defined: each step performs 4 back-to-back ADC_REQ/ADC_WAIT conversions and accumulates them into an ADC_BITWIDTH+2 sum. adc_sample_o = sum >> 2, truncated. The ADC_TIMEOUT limit applies per conversion, and a timeout aborts the whole step.
- Undefined: one conversion per step, and the accumulator and conversion counter are not synthesized.

Decomposition:
- Package fan_ctrl_pkg holds:
  - state enum: IDLE, ADC_REQ, ADC_WAIT, PID_REQ, PID_WAIT, UPDATE
  - default localparams for TICK_PERIOD, ADC_TIMEOUT, PWM_MIN_DUTY
  - a function computing the tick counter width: $clog2(TICK_PERIOD)
- One sub-module, fan_ctrl_tick_gen: a parameterised period counter with tick output.
- The FSM and the duty mapping stay in the top module.

Test Plan:
1. TICK_PERIOD=16, set_i=7, ADC answers 2 cycles after start with 5, PID answers r=+9 -> one adc_start_o, one pid_start_o, adc_sample_o=5, set_sample_o=7, duty_o=9 with duty_valid_o pulsed once per 16 cycles.
2. PID returns r=-4, then r=+1, then r=0 -> duty_o = 0, then 3, then 0.
3. ADC never answers, ADC_TIMEOUT=8 -> timeout_o sets 8 cycles after adc_start_o, no pid_start_o, duty_o holds its previous value; the next tick restarts the sequence.
4. pid_busy_i held high for 20 cycles with TICK_PERIOD=16 -> the tick during the step is dropped, exactly one duty_valid_o is produced, and the next step starts on the following tick.
5. rst_i asserted during PID_WAIT -> all outputs are 0 on the next cycle; with enable_i=0, no adc_start_o appears across 3 ticks.
6. With FAN_SEQ_OVERSAMPLE_EN defined, ADC returns 4, 5, 6, 7 -> four adc_start_o pulses in the step, sum 22, adc_sample_o=5.

Source files
------------

// File: rtl/fan_ctrl_pkg.sv
// Shared types and defaults for the fan control step sequencer.
// The oversampling option in the top is controlled by FAN_SEQ_OVERSAMPLE_EN.
package fan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADC_REQ,
    ADC_WAIT,
    PID_REQ,
    PID_WAIT,
    UPDATE
  } fan_state_t;

  localparam int TICK_PERIOD_DEF  = 200000;
  localparam int ADC_TIMEOUT_DEF  = 255;
  localparam int PWM_MIN_DUTY_DEF = 3;

  // Width of a counter that holds 0 .. period-1.
  function automatic int tick_cnt_w(input int period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/fan_ctrl_tick_gen.sv
// Free-running period counter; tick_o is high for the last count of each period.
module fan_ctrl_tick_gen
  import fan_ctrl_pkg::*;
#(
  parameter int TICK_PERIOD = TICK_PERIOD_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CNT_W = tick_cnt_w(TICK_PERIOD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_PERIOD - 1);

  logic [CNT_W-1:0] count;

  // Count 0 .. TICK_PERIOD-1 and wrap, independent of sequencer activity.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick_o = (count == LAST);

endmodule

// File: rtl/fan_ctrl_sequencer.sv
// One control step per tick: ADC conversion, PID iteration, duty update.
// Define FAN_SEQ_OVERSAMPLE_EN to average four conversions per step.
module fan_ctrl_sequencer
  import fan_ctrl_pkg::*;
#(
  parameter int ADC_BITWIDTH = 4,
  parameter int TICK_PERIOD  = TICK_PERIOD_DEF,
  parameter int ADC_TIMEOUT  = ADC_TIMEOUT_DEF,
  parameter int PWM_MIN_DUTY = PWM_MIN_DUTY_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [ADC_BITWIDTH-1:0] set_i,
  output logic                    adc_start_o,
  input  logic                    adc_done_i,
  input  logic [ADC_BITWIDTH-1:0] adc_data_i,
  output logic                    pid_start_o,
  input  logic                    pid_busy_i,
  input  logic [ADC_BITWIDTH:0]   pid_result_i,
  output logic [ADC_BITWIDTH-1:0] adc_sample_o,
  output logic [ADC_BITWIDTH-1:0] set_sample_o,
  output logic [ADC_BITWIDTH-1:0] duty_o,
  output logic                    duty_valid_o,
  output logic                    timeout_o
);

  localparam int WAIT_W = $clog2(ADC_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ADC_TIMEOUT - 1);
  localparam logic [ADC_BITWIDTH-1:0] MIN_DUTY = ADC_BITWIDTH'(PWM_MIN_DUTY);
  localparam logic signed [ADC_BITWIDTH:0] MIN_R = (ADC_BITWIDTH + 1)'(PWM_MIN_DUTY);

  // Non-positive results switch the fan off; small positive ones are lifted
  // to the minimum duty the fan can actually spin at.
  function automatic logic [ADC_BITWIDTH-1:0] map_duty(input logic signed [ADC_BITWIDTH:0] r);
    if (r[ADC_BITWIDTH] || (r == '0)) begin
      map_duty = '0;
    end else if (r < MIN_R) begin
      map_duty = MIN_DUTY;
    end else begin
      map_duty = r[ADC_BITWIDTH-1:0];
    end
  endfunction

  fan_state_t state, state_next;
  logic              tick;
  logic [WAIT_W-1:0] wait_cnt;
  logic              pid_first;
  logic              latch_set;
  logic              adc_accept;
  logic              set_timeout;
  logic              last_conv;
  logic [ADC_BITWIDTH-1:0] sample_value;

  fan_ctrl_tick_gen #(
    .TICK_PERIOD(TICK_PERIOD)
  ) u_tick_gen (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tick_o(tick)
  );

`ifdef FAN_SEQ_OVERSAMPLE_EN
  logic [ADC_BITWIDTH+1:0] acc;
  logic [ADC_BITWIDTH+1:0] acc_sum;
  logic [1:0]              conv_cnt;

  assign acc_sum      = acc + {2'b00, adc_data_i};
  assign last_conv    = (conv_cnt == 2'd3);
  assign sample_value = acc_sum[ADC_BITWIDTH+1:2];

  // Accumulate the four conversions of a step; cleared when a step starts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conv_cnt <= '0;
    end else if (latch_set) begin
      conv_cnt <= '0;
    end else if (adc_accept) begin
      conv_cnt <= conv_cnt + 1'b1;
    end
    if (latch_set) begin
      acc <= '0;
    end else if (adc_accept) begin
      acc <= acc_sum;
    end
  end
`else
  assign last_conv    = 1'b1;
  assign sample_value = adc_data_i;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and single-cycle handshake strobes.
  always_comb begin
    state_next  = state;
    adc_start_o = 1'b0;
    pid_start_o = 1'b0;
    latch_set   = 1'b0;
    adc_accept  = 1'b0;
    set_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (tick && enable_i) begin
          latch_set  = 1'b1;
          state_next = ADC_REQ;
        end
      end
      ADC_REQ: begin
        adc_start_o = 1'b1;
        state_next  = ADC_WAIT;
      end
      ADC_WAIT: begin
        if (adc_done_i) begin
          adc_accept = 1'b1;
          state_next = last_conv ? PID_REQ : ADC_REQ;
        end else if (wait_cnt == WAIT_LAST) begin
          set_timeout = 1'b1;
          state_next  = IDLE;
        end
      end
      PID_REQ: begin
        pid_start_o = 1'b1;
        state_next  = PID_WAIT;
      end
      PID_WAIT: begin
        // busy may lag start by a cycle, so the first cycle is not trusted
        if (!pid_first && !pid_busy_i) begin
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Count cycles spent waiting for the current conversion.
  always_ff @(posedge clk_i) begin
    if (state == ADC_REQ) begin
      wait_cnt <= '0;
    end else if (state == ADC_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Flag the first PID_WAIT cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pid_first <= 1'b0;
    end else begin
      pid_first <= (state == PID_REQ);
    end
  end

  // Output registers: samples, duty command, valid pulse and sticky timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      set_sample_o <= '0;
      adc_sample_o <= '0;
      duty_o       <= '0;
      duty_valid_o <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      duty_valid_o <= (state == UPDATE);
      if (latch_set) begin
        set_sample_o <= set_i;
      end
      if (adc_accept && last_conv) begin
        adc_sample_o <= sample_value;
      end
      if (set_timeout) begin
        timeout_o <= 1'b1;
      end
      if (state == UPDATE) begin
        duty_o <= map_duty(pid_result_i);
      end
    end
  end

endmodule

// File: tb/tb_fan_ctrl_sequencer.sv
// Directed bench for fan_ctrl_sequencer with small ADC and PID responder models.
module tb_fan_ctrl_sequencer;

  localparam int W       = 4;
  localparam int TP      = 16;
  localparam int TO      = 8;
  localparam int ADC_LAT = 2;
`ifdef FAN_SEQ_OVERSAMPLE_EN
  localparam int NCONV    = 4;
  localparam int STEP_GAP = 48;
`else
  localparam int NCONV    = 1;
  localparam int STEP_GAP = 32;
`endif
  localparam int LAT1 = 8 + 3 * (NCONV - 1);

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                enable_i;
  logic [W-1:0]        set_i;
  logic                adc_start_o;
  logic                adc_done_i = 1'b0;
  logic [W-1:0]        adc_data_i = '0;
  logic                pid_start_o;
  logic                pid_busy_i = 1'b0;
  logic signed [W:0]   pid_result_i;
  logic [W-1:0]        adc_sample_o;
  logic [W-1:0]        set_sample_o;
  logic [W-1:0]        duty_o;
  logic                duty_valid_o;
  logic                timeout_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int adc_starts = 0;
  int pid_starts = 0;
  int valids = 0;
  int adc_cd = 0;
  int busy_cd = 0;
  int busy_len = 2;
  int adc_val = 5;
  bit adc_answer = 1'b1;
  int adc_q[$];

  fan_ctrl_sequencer #(
    .ADC_BITWIDTH(W),
    .TICK_PERIOD (TP),
    .ADC_TIMEOUT (TO),
    .PWM_MIN_DUTY(3)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .set_i       (set_i),
    .adc_start_o (adc_start_o),
    .adc_done_i  (adc_done_i),
    .adc_data_i  (adc_data_i),
    .pid_start_o (pid_start_o),
    .pid_busy_i  (pid_busy_i),
    .pid_result_i(pid_result_i),
    .adc_sample_o(adc_sample_o),
    .set_sample_o(set_sample_o),
    .duty_o      (duty_o),
    .duty_valid_o(duty_valid_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
    end
  end

  // ADC model: answers ADC_LAT cycles after each start while adc_answer is set.
  initial begin
    forever begin
      @(negedge clk_i);
      adc_done_i = 1'b0;
      if (adc_cd > 0) begin
        adc_cd--;
        if (adc_cd == 0) begin
          adc_done_i = 1'b1;
          if (adc_q.size() > 0) adc_data_i = W'(adc_q.pop_front());
          else                  adc_data_i = W'(adc_val);
        end
      end
      if (adc_start_o) begin
        adc_starts++;
        if (adc_answer) adc_cd = ADC_LAT;
      end
    end
  end

  // PID model: busy for busy_len cycles starting the cycle after start.
  initial begin
    forever begin
      @(negedge clk_i);
      pid_busy_i = (busy_cd > 0);
      if (busy_cd > 0) busy_cd--;
      if (pid_start_o) begin
        busy_cd = busy_len;
        pid_starts++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (duty_valid_o) valids++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_i);
      #1;
    end
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return adc_start_o;
      1:       return pid_start_o;
      default: return duty_valid_o;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int max_cyc, input string tag);
    int n = 0;
    do begin
      step(1);
      n++;
    end while (!probe(sel) && n < max_cyc);
    check(tag, 32'(probe(sel)), 1);
  endtask

  int t0, t1, s0, p0, v0;
  int rv[6] = '{-4, 1, 0, 2, 15, 12};
  int dv[6] = '{ 0, 3, 0, 3, 15, 12};

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; set_i = '0; pid_result_i = '0;
    step(3);
    check("rst_adc_start", 32'(adc_start_o), 0);
    check("rst_pid_start", 32'(pid_start_o), 0);
    check("rst_duty", 32'(duty_o), 0);
    check("rst_duty_valid", 32'(duty_valid_o), 0);
    check("rst_timeout", 32'(timeout_o), 0);
    check("rst_adc_sample", 32'(adc_sample_o), 0);
    check("rst_set_sample", 32'(set_sample_o), 0);

    // Basic step: set 7, ADC 5, PID +9.
    rst_i = 1'b0; enable_i = 1'b1; set_i = 4'd7; pid_result_i = 5'sd9;
    s0 = adc_starts; p0 = pid_starts;
    wait_for(0, 40, "t1_adc_start");
    t0 = cyc;
    wait_for(2, 60, "t1_valid");
    check("t1_latency", 32'(cyc - t0), LAT1);
    check("t1_duty", 32'(duty_o), 9);
    check("t1_adc_sample", 32'(adc_sample_o), 5);
    check("t1_set_sample", 32'(set_sample_o), 7);
    check("t1_adc_starts", 32'(adc_starts - s0), NCONV);
    check("t1_pid_starts", 32'(pid_starts - p0), 1);
    t1 = cyc;
    step(1);
    check("t1_valid_pulse", 32'(duty_valid_o), 0);
    wait_for(2, 40, "t1_valid2");
    check("t1_period", 32'(cyc - t1), TP);

    // Duty mapping across signed results.
    for (int i = 0; i < 6; i++) begin
      pid_result_i = (W + 1)'(rv[i]);
      wait_for(2, 40, "t2_valid");
      check("t2_duty", 32'(duty_o), dv[i]);
    end

    // ADC never answers: sticky timeout, no PID, duty holds.
    adc_answer = 1'b0;
    p0 = pid_starts; v0 = valids;
    wait_for(0, 40, "t3_adc_start");
    step(7);
    check("t3_timeout_early", 32'(timeout_o), 0);
    step(2);
    check("t3_timeout_set", 32'(timeout_o), 1);
    check("t3_no_pid_start", 32'(pid_starts - p0), 0);
    check("t3_duty_hold", 32'(duty_o), 12);
    check("t3_no_valid", 32'(valids - v0), 0);
    adc_answer = 1'b1; pid_result_i = 5'sd9;
    wait_for(2, 40, "t3_restart_valid");
    check("t3_restart_duty", 32'(duty_o), 9);
    check("t3_timeout_sticky", 32'(timeout_o), 1);

    // Long PID busy: the tick inside the step is dropped.
    busy_len = 20;
    wait_for(0, 40, "t4_adc_start");
    t0 = cyc; v0 = valids; s0 = adc_starts;
    wait_for(2, 60, "t4_valid");
    wait_for(0, 60, "t4_next_start");
    check("t4_step_gap", 32'(cyc - t0), STEP_GAP);
    check("t4_one_valid", 32'(valids - v0), 1);
    check("t4_adc_starts", 32'(adc_starts - s0), NCONV);

    // Reset during PID_WAIT, then disabled for three ticks.
    wait_for(1, 60, "t5_pid_start");
    step(3);
    rst_i = 1'b1;
    step(1);
    check("t5_duty", 32'(duty_o), 0);
    check("t5_duty_valid", 32'(duty_valid_o), 0);
    check("t5_timeout", 32'(timeout_o), 0);
    check("t5_adc_sample", 32'(adc_sample_o), 0);
    check("t5_set_sample", 32'(set_sample_o), 0);
    check("t5_pid_start", 32'(pid_start_o), 0);
    check("t5_adc_start", 32'(adc_start_o), 0);
    rst_i = 1'b0; enable_i = 1'b0;
    s0 = adc_starts; v0 = valids;
    step(3 * TP + 4);
    check("t5_disabled_starts", 32'(adc_starts - s0), 0);
    check("t5_disabled_valids", 32'(valids - v0), 0);
    enable_i = 1'b1; busy_len = 2; pid_result_i = 5'sd5;
    wait_for(2, 60, "t5_resume_valid");
    check("t5_resume_duty", 32'(duty_o), 5);

    // Conversion values for the sample path.
    s0 = adc_starts;
`ifdef FAN_SEQ_OVERSAMPLE_EN
    adc_q.push_back(4); adc_q.push_back(5); adc_q.push_back(6); adc_q.push_back(7);
    wait_for(2, 60, "t6_valid");
    check("t6_adc_sample", 32'(adc_sample_o), 5);
    check("t6_adc_starts", 32'(adc_starts - s0), 4);
`else
    adc_q.push_back(11);
    wait_for(2, 60, "t6_valid");
    check("t6_adc_sample", 32'(adc_sample_o), 11);
    check("t6_adc_starts", 32'(adc_starts - s0), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
